// File: rtl/sipo_deserializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_deserializer_pkg
//  Description : Shared definitions for the serial-in parallel-out receiver:
//                default word width, bit_count width helper and the serial
//                link bit-order constant used by both ends of the link.
//  Revision    : 1.0  initial release
// ============================================================================
package sipo_deserializer_pkg;

    // Default parallel word width.
    localparam int unsigned SIPO_DEFAULT_WIDTH = 8;

    // Serial-link bit order, shared with the transmit-side shifters.
    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } bit_order_e;

    localparam bit_order_e SIPO_BIT_ORDER = MSB_FIRST;

    // Width of the bit counter for a given word width. Never below one bit
    // so the port always has a legal range.
    function automatic int unsigned sipo_count_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage : sipo_deserializer_pkg
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_deserializer
//  Description : Rebuilds WIDTH-bit words from a serial stream (MSB first),
//                sampled on a shift strobe. Completed words are placed in a
//                single-entry holding register with a valid/ready handshake;
//                a sticky overrun flag reports words dropped because the
//                holding register was still occupied.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk        : clock, all state updates on the rising edge
//    reset      : synchronous active-high reset (highest priority)
//    shift      : capture serial_in this cycle
//    serial_in  : serial data, MSB of each word first
//    clear      : discard partial word and clear overrun
//    data_ready : consumer accepts data_out this cycle
//    data_out   : last completed word (holding register)
//    data_valid : data_out holds an unconsumed word
//    overrun    : sticky, a completed word was dropped
//    busy       : a partial word is in progress
//    bit_count  : bits captured into the current partial word
// ============================================================================
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH = SIPO_DEFAULT_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 shift,
    input  logic                                 serial_in,
    input  logic                                 clear,
    input  logic                                 data_ready,
    output logic [WIDTH-1:0]                     data_out,
    output logic                                 data_valid,
    output logic                                 overrun,
    output logic                                 busy,
    output logic [sipo_count_width(WIDTH)-1:0]   bit_count
);

    localparam int unsigned CW = sipo_count_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // Only WIDTH-1 bits of history are ever needed: the final bit of a word
    // is taken straight from serial_in on the completion edge.
    logic [WIDTH-2:0] shift_reg;

    logic [WIDTH-1:0] assembled;
    logic             complete;
    logic             transfer;

    assign assembled = {shift_reg, serial_in};
    assign complete  = shift && !clear && (bit_count == LAST_BIT);
    assign transfer  = data_valid && data_ready;
    assign busy      = (bit_count != '0);

    // Capture path: partial word and bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            bit_count <= '0;
        end else if (clear) begin
            // clear wins over shift; the bit offered this cycle is lost.
            shift_reg <= '0;
            bit_count <= '0;
        end else if (shift) begin
            shift_reg <= assembled[WIDTH-2:0];
            bit_count <= complete ? '0 : bit_count + CW'(1);
        end
    end

    // Holding register, handshake and overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (complete) begin
                // A word leaving on this same edge frees the slot for the
                // new one, so back-to-back delivery needs no bubble.
                if (!data_valid || transfer) begin
                    data_out   <= assembled;
                    data_valid <= 1'b1;
                end
            end else if (transfer) begin
                data_valid <= 1'b0;
            end

            if (clear) begin
                overrun <= 1'b0;
            end else if (complete && data_valid && !transfer) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule : sipo_deserializer
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sipo_deserializer
//  Description : Self-checking bench for sipo_deserializer. Stimulus updates
//                a bit-queue reference model and pushes every word expected
//                to be delivered into a scoreboard queue; a monitor pops and
//                compares on each handshake transfer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sipo_deserializer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             shift = 1'b0;
    logic             serial_in = 1'b0;
    logic             clear = 1'b0;
    logic             data_ready = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             overrun;
    logic             busy;
    logic [2:0]       bit_count;

    sipo_deserializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .shift      (shift),
        .serial_in  (serial_in),
        .clear      (clear),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun),
        .busy       (busy),
        .bit_count  (bit_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    bit         bits[$];       // bits of the partial word, oldest first
    logic [7:0] exp_q[$];      // words expected to be handed to the consumer
    bit         m_valid = 0;
    bit         m_over  = 0;
    logic [7:0] m_data  = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge whenever
    // data_valid and data_ready are both high.
    always @(negedge clk) begin
        if (!reset && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", int'(data_out), -1);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("data_out_xfer", int'(data_out), int'(e));
            end
        end
    end

    // Compare visible state against the model, then apply one cycle.
    task automatic step(input bit r, input bit s, input bit b, input bit c, input bit rdy);
        bit         xfer;
        bit         done;
        int         word;

        chk("data_valid", int'(data_valid), int'(m_valid));
        chk("overrun",    int'(overrun),    int'(m_over));
        chk("bit_count",  int'(bit_count),  bits.size());
        chk("busy",       int'(busy),       int'(bits.size() != 0));
        chk("data_out",   int'(data_out),   int'(m_data));

        reset = r; shift = s; serial_in = b; clear = c; data_ready = rdy;

        xfer = m_valid && rdy;
        done = 0;
        word = 0;
        if (r) begin
            bits.delete();
            exp_q.delete();
            m_valid = 0;
            m_over  = 0;
            m_data  = '0;
        end else begin
            if (c) begin
                bits.delete();
                m_over = 0;
            end else if (s) begin
                bits.push_back(b);
                if (bits.size() == WIDTH) begin
                    foreach (bits[i]) word = word * 2 + int'(bits[i]);
                    bits.delete();
                    done = 1;
                end
            end
            if (done) begin
                if (!m_valid || xfer) begin
                    m_valid = 1;
                    m_data  = word[7:0];
                    exp_q.push_back(word[7:0]);
                end else begin
                    m_over = 1;
                end
            end else if (xfer) begin
                m_valid = 0;
            end
        end

        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input bit rdy);
        for (int i = WIDTH - 1; i >= 0; i--) step(0, 1, w[i], 0, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, rdy);
    endtask

    initial begin
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Single word, consumer ready.
        send_word(8'hA5, 1);
        idle(2, 1);

        // Two words back to back, no gap bits.
        send_word(8'h3C, 1);
        send_word(8'hC3, 1);
        idle(2, 1);

        // Consumer stalled: second word is dropped, overrun sticks.
        send_word(8'h12, 0);
        send_word(8'h34, 0);
        idle(2, 0);
        step(0, 0, 0, 0, 1);
        idle(2, 0);
        step(0, 0, 0, 1, 0);
        idle(1, 0);

        // Partial word discarded by clear coincident with shift.
        send_word(8'h77, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0);
        idle(1, 0);
        step(0, 0, 0, 0, 1);
        send_word(8'h81, 1);
        idle(2, 1);

        // Transfer coincident with completion of the next word.
        send_word(8'h55, 0);
        for (int i = WIDTH - 1; i >= 1; i--) step(0, 1, (8'hAA >> i) & 1, 0, 0);
        step(0, 1, 0, 0, 1);
        idle(2, 0);
        step(0, 0, 0, 0, 1);

        // Reset mid-word with a pending word.
        send_word(8'h99, 0);
        for (int i = 0; i < 5; i++) step(0, 1, i[0], 0, 0);
        step(1, 0, 0, 0, 0);
        send_word(8'hF0, 1);
        idle(2, 1);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 599) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 ($urandom_range(0, 79) == 0),
                 1'($urandom));
        end

        // Drain and confirm every expected word was delivered.
        idle(4, 1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_sipo_deserializer
`default_nettype wire
